// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
//   Iterative shift-add integer multiplier sitting on the reservation-station
//   issue protocol. It captures one station entry when both operand tags are
//   zero and pulses rs_release for one cycle. It then computes the 2*XLEN-bit
//   product one multiplier bit per cycle, LSB first. The selected half is held
//   on the result bus until the CDB arbiter grants it.
//
// Ports
//   CLOCK_50          in   clock, rising edge
//   RSTN_N            in   asynchronous active-low reset
//   rs_busy           in   station entry valid
//   rs_alu1/rs_alu2   in   producer tags of the operands (0 = value ready)
//   rs_value1/2       in   operands
//   rs_funct3         in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx MUL
//   rs_release        out  one-cycle pulse after the capture edge
//   flush             in   abort current operation, return to IDLE
//   result_grant      in   CDB arbiter accepts the result this cycle
//   result            out  low or high half of the product
//   result_tag        out  UNIT_ID while result_available, else 0
//   result_available  out  result valid, held until granted
//   unit_busy         out  high in CALC or WAIT_CDB
// ---------------------------------------------------------------------------
module mul_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter int UNIT_ID = 8
) (
  input  logic             CLOCK_50,
  input  logic             RSTN_N,
  input  logic             rs_busy,
  input  logic [TAG_W-1:0] rs_alu1,
  input  logic [TAG_W-1:0] rs_alu2,
  input  logic [XLEN-1:0]  rs_value1,
  input  logic [XLEN-1:0]  rs_value2,
  input  logic [2:0]       rs_funct3,
  output logic             rs_release,
  input  logic             flush,
  input  logic             result_grant,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_available,
  output logic             unit_busy
);

  localparam int              CNT_W  = $clog2(XLEN) + 1;
  localparam logic [TAG_W-1:0] LP_TAG = TAG_W'(UNIT_ID);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT} state_t;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic f_rs1_signed(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  // Only MULH treats rs2 as signed.
  function automatic logic f_rs2_signed(input logic [2:0] f3);
    return (f3 == 3'b001);
  endfunction

  // High half for 001/010/011; 000 and 1xx return the low half.
  function automatic logic f_hi_half(input logic [2:0] f3);
    return (f3[2] == 1'b0) && (f3[1:0] != 2'b00);
  endfunction

  state_t              r_state;
  logic [2*XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_hi;
  logic                r_sgn2;
  logic                r_release;
  logic                r_avail;
  logic                r_busy;
  logic [XLEN-1:0]     r_result;
  logic [TAG_W-1:0]    r_tag;

  logic                w_capture;
  logic                w_last;
  logic [2*XLEN-1:0]   w_rs1_ext;
  logic [2*XLEN-1:0]   w_acc_nxt;

  assign w_capture = rs_busy && (rs_alu1 == '0) && (rs_alu2 == '0) && !flush;
  assign w_last    = (r_cnt == CNT_W'(XLEN - 1));
  assign w_rs1_ext = f_rs1_signed(rs_funct3)
                     ? {{XLEN{rs_value1[XLEN-1]}}, rs_value1}
                     : {{XLEN{1'b0}}, rs_value1};

  // A signed rs2 carries weight -2^(XLEN-1) on its top bit, so that
  // partial product is subtracted rather than added.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0]) begin
      if (w_last && r_sgn2) w_acc_nxt = r_acc - r_mcand;
      else                  w_acc_nxt = r_acc + r_mcand;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_hi      <= 1'b0;
      r_sgn2    <= 1'b0;
      r_release <= 1'b0;
      r_avail   <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= '0;
      r_tag     <= '0;
    end else begin
      r_release <= 1'b0;
      if (flush) begin
        // Flush wins over grant and capture; any result in flight is lost.
        r_state  <= S_IDLE;
        r_avail  <= 1'b0;
        r_tag    <= '0;
        r_result <= '0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_capture) begin
              r_mcand   <= w_rs1_ext;
              r_mplier  <= rs_value2;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_hi      <= f_hi_half(rs_funct3);
              r_sgn2    <= f_rs2_signed(rs_funct3);
              r_release <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_CALC;
            end
          end
          S_CALC: begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= S_WAIT;
          end
          S_WAIT: begin
            // First WAIT cycle publishes the result; afterwards hold until grant.
            if (!r_avail) begin
              r_avail  <= 1'b1;
              r_tag    <= LP_TAG;
              r_result <= r_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
            end else if (result_grant) begin
              r_avail  <= 1'b0;
              r_tag    <= '0;
              r_result <= '0;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rs_release       = r_release;
  assign result           = r_result;
  assign result_tag       = r_tag;
  assign result_available = r_avail;
  assign unit_busy        = r_busy;

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  logic        CLOCK_50 = 1'b0;
  logic        RSTN_N = 1'b0;
  logic        rs_busy = 1'b0;
  logic [7:0]  rs_alu1 = 8'd0;
  logic [7:0]  rs_alu2 = 8'd0;
  logic [31:0] rs_value1 = 32'd0;
  logic [31:0] rs_value2 = 32'd0;
  logic [2:0]  rs_funct3 = 3'd0;
  logic        rs_release;
  logic        flush = 1'b0;
  logic        result_grant = 1'b0;
  logic [31:0] result;
  logic [7:0]  result_tag;
  logic        result_available;
  logic        unit_busy;

  int total = 0;
  int bad = 0;

  mul_unit #(.XLEN(32), .TAG_W(8), .UNIT_ID(8)) dut (
    .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N), .rs_busy(rs_busy),
    .rs_alu1(rs_alu1), .rs_alu2(rs_alu2), .rs_value1(rs_value1),
    .rs_value2(rs_value2), .rs_funct3(rs_funct3), .rs_release(rs_release),
    .flush(flush), .result_grant(result_grant), .result(result),
    .result_tag(result_tag), .result_available(result_available),
    .unit_busy(unit_busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a ready entry, follow it through capture, and return the
  // result and the number of edges from capture to result_available.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bit done;
    rs_funct3 = f3; rs_value1 = a; rs_value2 = b;
    rs_alu1 = 8'd0; rs_alu2 = 8'd0; rs_busy = 1'b1;
    @(negedge CLOCK_50);
    chk({tag, "_release"}, 32'(rs_release), 32'd1);
    rs_busy = 1'b0; rs_value1 = 32'hDEAD_BEEF; rs_value2 = 32'h1234_5678;
    lat = 0; done = 1'b0;
    for (int i = 1; i <= 100 && !done; i++) begin
      @(negedge CLOCK_50);
      if (result_available) begin lat = i; done = 1'b1; end
    end
    if (!done) chk({tag, "_timeout"}, 32'(result_available), 32'd1);
    res = result;
  endtask

  task automatic grant_and_check(input string tag);
    result_grant = 1'b1;
    @(negedge CLOCK_50);
    result_grant = 1'b0;
    chk({tag, "_gnt_avail"}, 32'(result_available), 32'd0);
    chk({tag, "_gnt_result"}, result, 32'd0);
    chk({tag, "_gnt_busy"}, 32'(unit_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int cnt;

    // Reset state
    repeat (2) @(negedge CLOCK_50);
    chk("rst_avail", 32'(result_available), 32'd0);
    chk("rst_tag", 32'(result_tag), 32'd0);
    chk("rst_release", 32'(rs_release), 32'd0);
    chk("rst_busy", 32'(unit_busy), 32'd0);
    RSTN_N = 1'b1;
    @(negedge CLOCK_50);

    // 1. MUL 7*6, latency and tag
    rs_funct3 = 3'b000; rs_value1 = 32'd7; rs_value2 = 32'd6;
    rs_alu1 = 8'd0; rs_alu2 = 8'd0; rs_busy = 1'b1;
    @(negedge CLOCK_50);
    chk("t1_release", 32'(rs_release), 32'd1);
    chk("t1_busy", 32'(unit_busy), 32'd1);
    rs_busy = 1'b0;
    @(negedge CLOCK_50);
    chk("t1_release_pulse", 32'(rs_release), 32'd0);
    cnt = 0;
    for (int i = 2; i <= 32; i++) begin
      @(negedge CLOCK_50);
      if (result_available) cnt++;
    end
    chk("t1_early_avail", 32'(cnt), 32'd0);
    @(negedge CLOCK_50);
    chk("t1_avail_33", 32'(result_available), 32'd1);
    chk("t1_result", result, 32'd42);
    chk("t1_tag", 32'(result_tag), 32'd8);
    grant_and_check("t1");

    // 2. MULH / MUL on 0x80000000 * 0x80000000
    run_op("t2h", 3'b001, 32'h8000_0000, 32'h8000_0000, res, lat);
    chk("t2_mulh", res, 32'h4000_0000);
    chk("t2_lat", 32'(lat), 32'd33);
    grant_and_check("t2h");
    run_op("t2l", 3'b000, 32'h8000_0000, 32'h8000_0000, res, lat);
    chk("t2_mul", res, 32'h0000_0000);
    grant_and_check("t2l");

    // 3. MULHSU / MULHU on 0xFFFFFFFF * 0xFFFFFFFF, plus a funct3=1xx alias
    run_op("t3su", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    chk("t3_mulhsu", res, 32'hFFFF_FFFF);
    grant_and_check("t3su");
    run_op("t3u", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    chk("t3_mulhu", res, 32'hFFFF_FFFE);
    grant_and_check("t3u");
    run_op("t3x", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    chk("t3_f3_1xx_low", res, 32'h0000_0001);
    grant_and_check("t3x");
    run_op("t3m", 3'b001, 32'hFFFF_FFFD, 32'h0000_0007, res, lat);
    chk("t3_mulh_neg", res, 32'hFFFF_FFFF);
    grant_and_check("t3m");

    // 4. Operand not ready for 10 cycles
    rs_funct3 = 3'b000; rs_value1 = 32'd12; rs_value2 = 32'd11;
    rs_alu1 = 8'd0; rs_alu2 = 8'd3; rs_busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (rs_release || unit_busy) cnt++;
    end
    chk("t4_no_capture", 32'(cnt), 32'd0);
    rs_alu2 = 8'd0;
    @(negedge CLOCK_50);
    chk("t4_capture", 32'(rs_release), 32'd1);
    rs_busy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100 && cnt == 0; i++) begin
      @(negedge CLOCK_50);
      if (result_available) cnt = 1;
    end
    chk("t4_result", result, 32'd132);
    grant_and_check("t4");

    // 5. Grant withheld, then grant with a second entry waiting
    run_op("t5", 3'b000, 32'd3, 32'd5, res, lat);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      if (result !== 32'd15 || !result_available || result_tag !== 8'd8) cnt++;
    end
    chk("t5_stable", 32'(cnt), 32'd0);
    result_grant = 1'b1;
    rs_funct3 = 3'b000; rs_value1 = 32'd2; rs_value2 = 32'd9;
    rs_alu1 = 8'd0; rs_alu2 = 8'd0; rs_busy = 1'b1;
    @(negedge CLOCK_50);
    result_grant = 1'b0;
    chk("t5_cleared", 32'(result_available), 32'd0);
    chk("t5_no_early_capture", 32'(rs_release), 32'd0);
    @(negedge CLOCK_50);
    chk("t5_second_capture", 32'(rs_release), 32'd1);
    rs_busy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100 && cnt == 0; i++) begin
      @(negedge CLOCK_50);
      if (result_available) cnt = 1;
    end
    chk("t5_second_result", result, 32'd18);
    grant_and_check("t5b");

    // 6a. Flush at CALC cycle 10
    rs_funct3 = 3'b000; rs_value1 = 32'd100; rs_value2 = 32'd100;
    rs_busy = 1'b1;
    @(negedge CLOCK_50);
    rs_busy = 1'b0;
    repeat (9) @(negedge CLOCK_50);
    flush = 1'b1;
    @(negedge CLOCK_50);
    flush = 1'b0;
    chk("t6_flush_busy", 32'(unit_busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (result_available) cnt++;
    end
    chk("t6_flush_no_avail", 32'(cnt), 32'd0);

    // 6b. Flush coinciding with a capture condition
    rs_busy = 1'b1; flush = 1'b1;
    @(negedge CLOCK_50);
    rs_busy = 1'b0; flush = 1'b0;
    chk("t6_flush_cap_release", 32'(rs_release), 32'd0);
    chk("t6_flush_cap_busy", 32'(unit_busy), 32'd0);

    // 6c. Asynchronous reset mid-CALC
    rs_busy = 1'b1;
    @(negedge CLOCK_50);
    rs_busy = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    #2 RSTN_N = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(unit_busy), 32'd0);
    chk("t6_rst_avail", 32'(result_available), 32'd0);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (result_available || unit_busy) cnt++;
    end
    chk("t6_rst_discard", 32'(cnt), 32'd0);

    // 6d. Asynchronous reset while a result is held
    run_op("t6d", 3'b000, 32'd9, 32'd9, res, lat);
    chk("t6d_result", res, 32'd81);
    #2 RSTN_N = 1'b0;
    #1;
    chk("t6d_rst_avail", 32'(result_available), 32'd0);
    chk("t6d_rst_tag", 32'(result_tag), 32'd0);
    chk("t6d_rst_result", result, 32'd0);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
    @(negedge CLOCK_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
